// File: rtl/if_prefetch_buf.sv
// Sequential instruction prefetch queue between instruction ROM and the core's fetch stage.
// Optional macro PREFETCH_BYPASS_EN forwards a ROM word straight to the core when the queue is empty.
module if_prefetch_buf #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rest,
    input  logic                       flush_i,
    input  logic [31:0]                flush_addr_i,
    output logic                       rom_req_o,
    output logic [31:0]                rom_addr_o,
    input  logic                       rom_ack_i,
    input  logic [31:0]                rom_data_i,
    output logic                       ins_valid_o,
    output logic [31:0]                ins_o,
    output logic [31:0]                ins_addr_o,
    input  logic                       ins_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FULL} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   mem_data [DEPTH];
    logic [31:0]   mem_addr [DEPTH];

    logic push;
    logic q_push;
    logic q_pop;
    logic bypass_take;
    logic not_empty;

    assign push      = rom_req_o & rom_ack_i & ~flush_i;
    assign not_empty = (count != '0);
    assign q_pop     = not_empty & ins_ready_i;
    assign q_push    = push & ~bypass_take;

`ifdef PREFETCH_BYPASS_EN
    logic bypass_hit;
    // An empty queue lets the word being acked pass straight through to the core.
    assign bypass_hit  = push & ~not_empty;
    assign bypass_take = bypass_hit & ins_ready_i;
    assign ins_valid_o = not_empty | bypass_hit;
    assign ins_o       = not_empty ? mem_data[rd_ptr] : (bypass_hit ? rom_data_i : 32'h0);
    assign ins_addr_o  = not_empty ? mem_addr[rd_ptr] : (bypass_hit ? fetch_pc   : 32'h0);
`else
    assign bypass_take = 1'b0;
    assign ins_valid_o = not_empty;
    assign ins_o       = not_empty ? mem_data[rd_ptr] : 32'h0;
    assign ins_addr_o  = not_empty ? mem_addr[rd_ptr] : 32'h0;
`endif

    assign rom_addr_o = fetch_pc;
    assign count_o    = count;

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state     <= S_IDLE;
            rom_req_o <= 1'b0;
            fetch_pc  <= RESET_ADDR;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else if (flush_i) begin
            // A pop in this cycle is irrelevant: the core already took the word.
            state     <= S_FETCH;
            rom_req_o <= 1'b1;
            fetch_pc  <= flush_addr_i;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            if (push)   fetch_pc <= fetch_pc + 32'd4;
            if (q_push) wr_ptr   <= wr_ptr + PW'(1);
            if (q_pop)  rd_ptr   <= rd_ptr + PW'(1);
            count <= count + CW'(q_push) - CW'(q_pop);
            case (state)
                S_IDLE: begin
                    state     <= S_FETCH;
                    rom_req_o <= 1'b1;
                end
                S_FETCH: begin
                    if (q_push && !q_pop && count == CW'(DEPTH - 1)) begin
                        state     <= S_FULL;
                        rom_req_o <= 1'b0;
                    end
                end
                S_FULL: begin
                    if (q_pop) begin
                        state     <= S_FETCH;
                        rom_req_o <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    rom_req_o <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: storage has no reset; stale entries are never visible because outputs are gated by count.
    always_ff @(posedge clk) begin
        if (q_push) begin
            mem_data[wr_ptr] <= rom_data_i;
            mem_addr[wr_ptr] <= fetch_pc;
        end
    end
endmodule

// File: tb/tb_if_prefetch_buf.sv
// Scoreboard bench for if_prefetch_buf: expected words queued on ROM ack, compared on core pop.
// Honours PREFETCH_BYPASS_EN when defined for both bench and design.
module tb_if_prefetch_buf;
    localparam int          DEPTH      = 4;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rest = 1'b1;
    logic        flush_i = 1'b0;
    logic [31:0] flush_addr_i = '0;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        rom_ack_i = 1'b0;
    logic [31:0] rom_data_i = '0;
    logic        ins_valid_o;
    logic [31:0] ins_o;
    logic [31:0] ins_addr_o;
    logic        ins_ready_i = 1'b0;
    logic [2:0]  count_o;

    int          total = 0;
    int          bad = 0;
    logic [63:0] sb[$];
    logic [31:0] exp_pc = RESET_ADDR;

    if_prefetch_buf #(.DEPTH(DEPTH), .RESET_ADDR(RESET_ADDR)) dut (
        .clk(clk), .rest(rest), .flush_i(flush_i), .flush_addr_i(flush_addr_i),
        .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_ack_i(rom_ack_i),
        .rom_data_i(rom_data_i), .ins_valid_o(ins_valid_o), .ins_o(ins_o),
        .ins_addr_o(ins_addr_o), .ins_ready_i(ins_ready_i), .count_o(count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus, driven and sampled in the low phase.
    task automatic step(input logic ack, input logic rdy, input logic fl, input logic [31:0] fa);
        int          pre;
        logic        push;
        logic [63:0] e;
        @(negedge clk);
        rom_ack_i    = ack;
        ins_ready_i  = rdy;
        flush_i      = fl;
        flush_addr_i = fa;
        rom_data_i   = rom_word(rom_addr_o);
        #1;
        pre = sb.size();
        check("count", 32'(count_o), 32'(pre));
        check("req", 32'(rom_req_o), 32'(pre < DEPTH));
        check("rom_addr", rom_addr_o, exp_pc);
        push = rom_req_o && ack && !fl;
`ifdef PREFETCH_BYPASS_EN
        check("valid", 32'(ins_valid_o), 32'((pre != 0) || push));
`else
        check("valid", 32'(ins_valid_o), 32'(pre != 0));
`endif
        if (push) sb.push_back({exp_pc, rom_word(exp_pc)});
        if (ins_valid_o && rdy) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got addr=%h expected no word at %0t", ins_addr_o, $time);
            end else begin
                e = sb.pop_front();
                check("ins_addr", ins_addr_o, e[63:32]);
                check("ins", ins_o, e[31:0]);
            end
        end
        if (fl) begin
            sb.delete();
            exp_pc = fa;
        end else if (push) begin
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rom_ack_i   = 1'b0;
        ins_ready_i = 1'b0;
        flush_i     = 1'b0;
        rest        = 1'b1;
        #1;
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_valid", 32'(ins_valid_o), 32'd0);
        check("rst_req", 32'(rom_req_o), 32'd0);
        check("rst_addr", rom_addr_o, RESET_ADDR);
        check("rst_ins", ins_o, 32'd0);
        check("rst_ins_addr", ins_addr_o, 32'd0);
        repeat (2) @(negedge clk);
        rest = 1'b0;
        #1;
        check("idle_req", 32'(rom_req_o), 32'd0);
        sb.delete();
        exp_pc = RESET_ADDR;
    endtask

    initial begin
        logic [31:0] ra;
        reset_dut();

        // Streaming: ack and ready every cycle.
        repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Core stalls: queue fills to DEPTH and stops requesting.
        repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("full_count", 32'(count_o), 32'(DEPTH));
        check("full_req", 32'(rom_req_o), 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("req_reassert", 32'(rom_req_o), 32'd1);

        // Flush with an ack in the same cycle while three entries are held.
        step(1'b0, 1'b0, 1'b1, 32'h200);
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h100);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("flush_count", 32'(count_o), 32'd0);
        check("flush_addr", rom_addr_o, 32'h100);
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Address wrap at the top of the address space.
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Random mix of acks, stalls and redirects, including full with push/pop pressure.
        for (int i = 0; i < 400; i++) begin
            ra = $urandom();
            ra[1:0] = 2'b00;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 29) == 0), ra);
        end

        // Reset in the middle of a fill.
        step(1'b0, 1'b0, 1'b1, 32'h40);
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("midfill_count", 32'(count_o), 32'd2);
        reset_dut();
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);

`ifdef PREFETCH_BYPASS_EN
        reset_dut();
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("byp_valid", 32'(ins_valid_o), 32'd1);
        check("byp_count", 32'(count_o), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("byp_after_count", 32'(count_o), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
